// File: rtl/reset_sequencer_if.sv
// Board reset/button bundle between the clock wizard, the push-button pin and the SoC.
// master = the sequencer itself, slave = the surrounding FPGA top (or a bench).
interface reset_sequencer_if;
  logic       pll_locked;
  logic       button_i;
  logic       soc_rst_n;
  logic       button_pressed;
  logic [1:0] reset_cause;

  modport master (
    input  pll_locked,
    input  button_i,
    output soc_rst_n,
    output button_pressed,
    output reset_cause
  );

  modport slave (
    output pll_locked,
    output button_i,
    input  soc_rst_n,
    input  button_pressed,
    input  reset_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// Qualifies MMCM lock, stretches and releases the SoC reset synchronously, debounces
// the centre button (optional soft reset) and records why the SoC was last reset.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int STRETCH_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter bit BUTTON_RESET_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reset_sequencer_if.master     bus
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STRETCH_CYCLES) ? LOCK_STABLE_CYCLES
                                                                 : STRETCH_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] CAUSE_EXT    = 2'b00;
  localparam logic [1:0] CAUSE_LOCK   = 2'b01;
  localparam logic [1:0] CAUSE_BUTTON = 2'b10;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } state_e;

  logic [1:0]    lock_sync_q;
  logic [1:0]    btn_sync_q;
  logic          locked_s;
  logic          button_s;

  logic          stable_q;
  logic          stable_d;
  logic          stable_prev_q;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic          pressed_q;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          soc_rst_n_q;
  logic [1:0]    cause_q;

  assign locked_s = lock_sync_q[1];
  assign button_s = btn_sync_q[1];

  // Two-flop synchronizers for the asynchronous lock and button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
      btn_sync_q  <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], bus.pll_locked};
      btn_sync_q  <= {btn_sync_q[0], bus.button_i};
    end
  end

  // Debounce next state: a new level is accepted only after holding DEBOUNCE_CYCLES
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    if (button_s == stable_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = button_s;
      dcnt_d   = '0;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  // Debounce state and the rising-edge pulse, one cycle behind the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      dcnt_q        <= '0;
      pressed_q     <= 1'b0;
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      dcnt_q        <= dcnt_d;
      pressed_q     <= stable_q & ~stable_prev_q;
    end
  end

  // Sequencer FSM; lock loss overrides everything, including a same-cycle press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      soc_rst_n_q <= 1'b0;
      cause_q     <= CAUSE_EXT;
    end else if (!locked_s) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      soc_rst_n_q <= 1'b0;
      if (state_q != WAIT_LOCK) begin
        cause_q <= CAUSE_LOCK;
      end
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_q <= STRETCH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STRETCH: begin
          if (cnt_q == CW'(STRETCH_CYCLES - 1)) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            soc_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (pressed_q && BUTTON_RESET_EN) begin
            state_q     <= STRETCH;
            cnt_q       <= '0;
            soc_rst_n_q <= 1'b0;
            cause_q     <= CAUSE_BUTTON;
          end
        end
        default: begin
          state_q     <= WAIT_LOCK;
          cnt_q       <= '0;
          soc_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.soc_rst_n      = soc_rst_n_q;
  assign bus.button_pressed = pressed_q;
  assign bus.reset_cause    = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: two instances (button reset enabled/disabled)
// share stimulus; a cycle-level reference model predicts every output event.
module tb_reset_sequencer;

  localparam int LK = 4;
  localparam int ST = 8;
  localparam int DB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic pll   = 1'b0;
  logic btn   = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer_if bus0();
  reset_sequencer_if bus1();

  assign bus0.pll_locked = pll;
  assign bus0.button_i   = btn;
  assign bus1.pll_locked = pll;
  assign bus1.button_i   = btn;

  reset_sequencer #(.LOCK_STABLE_CYCLES(LK), .STRETCH_CYCLES(ST),
                    .DEBOUNCE_CYCLES(DB), .BUTTON_RESET_EN(1'b1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  reset_sequencer #(.LOCK_STABLE_CYCLES(LK), .STRETCH_CYCLES(ST),
                    .DEBOUNCE_CYCLES(DB), .BUTTON_RESET_EN(1'b0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int cyc;
    int dut;
    int kind;   // 0: soc_rst_n change, 1: button pulse
    int val;
    int cause;
  } ev_t;

  ev_t sbq[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  // reference model state (phase 0 wait, 1 stretch, 2 run)
  int mode[2], good[2], el[2], cause_m[2], pr_m[2], rose_m[2], lvl[2], dcnt[2], en_m[2];
  int lh0, lh1, bh0, bh1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; good[i] = 0; el[i] = 0; cause_m[i] = 0;
      pr_m[i] = 0; rose_m[i] = 0; lvl[i] = 0; dcnt[i] = 0;
    end
    en_m[0] = 1; en_m[1] = 0;
    lh0 = 0; lh1 = 0; bh0 = 0; bh1 = 0;
    sbq.delete();
  endtask

  task automatic model_step();
    int  sl, sb, was_run, now_run;
    ev_t e;
    sl = lh1; lh1 = lh0; lh0 = int'(pll);
    sb = bh1; bh1 = bh0; bh0 = int'(btn);
    for (int i = 0; i < 2; i++) begin
      was_run = (mode[i] == 2) ? 1 : 0;
      if (sl == 0) begin
        if (mode[i] != 0) cause_m[i] = 1;
        mode[i] = 0; good[i] = 0;
      end else if (mode[i] == 0) begin
        good[i]++;
        if (good[i] == LK) begin mode[i] = 1; el[i] = 0; good[i] = 0; end
      end else if (mode[i] == 1) begin
        el[i]++;
        if (el[i] == ST) mode[i] = 2;
      end else if (pr_m[i] == 1 && en_m[i] == 1) begin
        mode[i] = 1; el[i] = 0; cause_m[i] = 2;
      end
      pr_m[i]   = rose_m[i];
      rose_m[i] = 0;
      if (sb == lvl[i]) begin
        dcnt[i] = 0;
      end else begin
        dcnt[i]++;
        if (dcnt[i] == DB) begin lvl[i] = sb; dcnt[i] = 0; rose_m[i] = sb; end
      end
      now_run = (mode[i] == 2) ? 1 : 0;
      if (now_run != was_run) begin
        e.cyc = cyc; e.dut = i; e.kind = 0; e.val = now_run; e.cause = cause_m[i];
        sbq.push_back(e);
      end
      if (pr_m[i] == 1) begin
        e.cyc = cyc; e.dut = i; e.kind = 1; e.val = 1; e.cause = cause_m[i];
        sbq.push_back(e);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0;
        model_reset();
      end else begin
        cyc++;
        model_step();
      end
    end
  end

  task automatic get_out(input int i, output int s, output int p, output int c);
    if (i == 0) begin
      s = int'(bus0.soc_rst_n); p = int'(bus0.button_pressed); c = int'(bus0.reset_cause);
    end else begin
      s = int'(bus1.soc_rst_n); p = int'(bus1.button_pressed); c = int'(bus1.reset_cause);
    end
  endtask

  task automatic sb_match(input int i, input int kind, input int val, input int cause);
    ev_t e;
    total++;
    if (sbq.size() == 0 || sbq[0].cyc != cyc || sbq[0].dut != i || sbq[0].kind != kind) begin
      bad++;
      $display("FAIL sb_unexpected: dut%0d kind %0d val %0d at cyc %0d, none expected", i, kind, val, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.val != val || e.cause != cause) begin
        bad++;
        $display("FAIL sb_event dut%0d kind %0d cyc %0d: got val %0d cause %0d expected val %0d cause %0d",
                 i, kind, cyc, val, cause, e.val, e.cause);
      end
    end
  endtask

  int ps[2];

  // monitor: compares DUT output events against the scoreboard
  initial begin
    int s, p, c;
    ev_t e;
    ps[0] = 0; ps[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ps[0] = 0; ps[1] = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          get_out(i, s, p, c);
          if (s != ps[i]) begin
            sb_match(i, 0, s, c);
            ps[i] = s;
          end
          if (p == 1) sb_match(i, 1, 1, c);
        end
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          e = sbq.pop_front();
          total++; bad++;
          $display("FAIL sb_missing: dut%0d kind %0d val %0d expected at cyc %0d not seen",
                   e.dut, e.kind, e.val, e.cyc);
        end
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_soc0"},   int'(bus0.soc_rst_n), 0);
    chk({tag, "_pr0"},    int'(bus0.button_pressed), 0);
    chk({tag, "_cause0"}, int'(bus0.reset_cause), 0);
    chk({tag, "_soc1"},   int'(bus1.soc_rst_n), 0);
    chk({tag, "_pr1"},    int'(bus1.button_pressed), 0);
    chk({tag, "_cause1"}, int'(bus1.reset_cause), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f, c0, pc0, pc1, pl_hold, bt_hold;

    // power-up
    #1 rst_n = 1'b0;
    #2 check_reset_vals("por");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_to(9);
    pll = 1'b1;
    wait_to(22);
    chk("pwr_soc0_e22", int'(bus0.soc_rst_n), 0);
    chk("pwr_soc1_e22", int'(bus1.soc_rst_n), 0);
    wait_to(23);
    chk("pwr_soc0_e23", int'(bus0.soc_rst_n), 1);
    chk("pwr_soc1_e23", int'(bus1.soc_rst_n), 1);
    chk("pwr_cause0",   int'(bus0.reset_cause), 0);
    repeat (5) @(negedge clk);

    // lock loss in RUN
    c0 = cyc;
    pll = 1'b0;
    wait_to(c0 + 2);
    chk("loss_soc0_k1", int'(bus0.soc_rst_n), 1);
    wait_to(c0 + 3);
    chk("loss_soc0_k2", int'(bus0.soc_rst_n), 0);
    chk("loss_cause0",  int'(bus0.reset_cause), 1);
    chk("loss_cause1",  int'(bus1.reset_cause), 1);

    // lock glitch after 3 counted cycles in WAIT_LOCK
    pll = 1'b1;
    repeat (3) @(negedge clk);
    pll = 1'b0;
    @(negedge clk);
    pll = 1'b1;
    c0 = cyc;
    wait_to(c0 + 13);
    chk("glitch_soc0_early", int'(bus0.soc_rst_n), 0);
    wait_to(c0 + 14);
    chk("glitch_soc0_rel", int'(bus0.soc_rst_n), 1);
    chk("glitch_soc1_rel", int'(bus1.soc_rst_n), 1);
    repeat (5) @(negedge clk);

    // bouncing button, then held high
    pc0 = 0; pc1 = 0;
    for (int t = 0; t < 8; t++) begin
      btn = ~btn;
      repeat (5) begin
        @(negedge clk);
        pc0 += int'(bus0.button_pressed);
        pc1 += int'(bus1.button_pressed);
      end
    end
    chk("bounce_no_pulse0", pc0, 0);
    btn = 1'b1;
    f = cyc;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      pc0 += int'(bus0.button_pressed);
      pc1 += int'(bus1.button_pressed);
      if (n == 18) chk("btn_pr0_early", int'(bus0.button_pressed), 0);
      if (n == 19) chk("btn_pr0_pulse", int'(bus0.button_pressed), 1);
      if (n == 19) chk("btn_pr1_pulse", int'(bus1.button_pressed), 1);
      if (n == 20) chk("soft_soc0_fall", int'(bus0.soc_rst_n), 0);
      if (n == 20) chk("soft_cause0", int'(bus0.reset_cause), 2);
      if (n == 24) chk("noen_soc1", int'(bus1.soc_rst_n), 1);
      if (n == 27) chk("soft_soc0_held", int'(bus0.soc_rst_n), 0);
      if (n == 28) chk("soft_soc0_rel", int'(bus0.soc_rst_n), 1);
    end
    chk("btn_pulse_count0", pc0, 1);
    chk("btn_pulse_count1", pc1, 1);
    btn = 1'b0;
    repeat (30) @(negedge clk);

    // randomized lock drops and button activity
    pl_hold = 0; bt_hold = 0;
    for (int n = 0; n < 2500; n++) begin
      if (pl_hold > 0) begin
        pl_hold--;
        if (pl_hold == 0) pll = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        pll = 1'b0;
        pl_hold = int'($urandom_range(1, 4));
      end
      if (bt_hold > 0) begin
        bt_hold--;
      end else begin
        btn = ~btn;
        bt_hold = int'($urandom_range(1, 40));
      end
      @(negedge clk);
    end
    pll = 1'b1;
    btn = 1'b0;
    repeat (60) @(negedge clk);

    // async reset mid-STRETCH and mid-debounce
    chk("pre_rst_soc0", int'(bus0.soc_rst_n), 1);
    pll = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_cause0", int'(bus0.reset_cause), 1);
    pll = 1'b1;
    btn = 1'b1;
    for (int n = 0; n < 40 && mode[0] != 1; n++) @(negedge clk);
    chk("reach_stretch", mode[0], 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    check_reset_vals("midrst_hold");
    #2 rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // async reset while running
    for (int n = 0; n < 60 && mode[0] != 2; n++) @(negedge clk);
    chk("run_soc0", int'(bus0.soc_rst_n), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("runrst");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    btn = 1'b0;
    repeat (60) @(negedge clk);

    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
